// File: rtl/fp_div_sqrt_iter_if.sv
// Request/response bundle of the iterative divide/sqrt mantissa core.
// Both channels use valid/ready: a transfer happens on a rising clk edge where valid && ready;
// the source holds valid and its payload stable until that edge, and ready may depend on valid.
interface fp_div_sqrt_iter_if #(
    parameter int TAG_WIDTH = 8
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_is_divide;
    logic                 req_bypass;
    logic                 req_expo_odd;
    logic [23:0]          req_lhs_mant;
    logic [23:0]          req_rhs_mant;
    logic [TAG_WIDTH-1:0] req_tag;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [25:0]          resp_quo;
    logic [27:0]          resp_rem;
    logic                 resp_sticky;
    logic [TAG_WIDTH-1:0] resp_tag;

    modport master (
        output req_valid, req_is_divide, req_bypass, req_expo_odd,
               req_lhs_mant, req_rhs_mant, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_quo, resp_rem, resp_sticky, resp_tag
    );

    modport slave (
        input  req_valid, req_is_divide, req_bypass, req_expo_odd,
               req_lhs_mant, req_rhs_mant, req_tag, resp_ready,
        output req_ready, resp_valid, resp_quo, resp_rem, resp_sticky, resp_tag
    );
endinterface

// File: rtl/fp_div_sqrt_iter.sv
// Restoring radix-2 divide/sqrt mantissa recurrence, one op in flight.
// Define FP_DIV_SQRT_RADIX4_EN to chain two radix-2 steps per cycle (13 iterations instead of 26).
module fp_div_sqrt_iter #(
    parameter int TAG_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    fp_div_sqrt_iter_if.slave  bus,
    output logic [1:0]         dbg_state
);

`ifdef FP_DIV_SQRT_RADIX4_EN
    localparam int ITERS = 13;
`else
    localparam int ITERS = 26;
`endif
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    // quo doubles as the partial root; rad holds radicand bits not yet consumed
    typedef struct packed {
        logic [25:0] quo;
        logic [27:0] rem;
        logic [51:0] rad;
    } dp_t;

    state_t               state, state_next;
    dp_t                  dp, dp_next;
    logic [CNT_W-1:0]     counter;
    logic [23:0]          divisor;
    logic                 is_div;
    logic [TAG_WIDTH-1:0] tag_q;
    logic                 accept;
    logic                 last_step;
    logic [24:0]          sqrt_r;

    function automatic dp_t recur_step(input dp_t s, input logic div, input logic [23:0] d,
                                       input logic last);
        dp_t         n;
        logic [27:0] r;
        logic [27:0] t;
        n = s;
        if (div) begin
            if (s.rem >= {4'b0, d}) begin
                n.rem = s.rem - {4'b0, d};
                n.quo = {s.quo[24:0], 1'b1};
            end else begin
                n.quo = {s.quo[24:0], 1'b0};
            end
            // the final remainder is left unscaled
            if (!last) n.rem = {n.rem[26:0], 1'b0};
        end else begin
            r     = {s.rem[25:0], s.rad[51:50]};
            t     = {s.quo, 2'b01};
            n.rad = {s.rad[49:0], 2'b00};
            if (r >= t) begin
                n.rem = r - t;
                n.quo = {s.quo[24:0], 1'b1};
            end else begin
                n.rem = r;
                n.quo = {s.quo[24:0], 1'b0};
            end
        end
        return n;
    endfunction

    assign bus.req_ready = (state == IDLE) && !flush;
    assign accept        = bus.req_valid && bus.req_ready;
    assign last_step     = (counter == '0);
    assign sqrt_r        = bus.req_expo_odd ? {bus.req_lhs_mant, 1'b0} : {1'b0, bus.req_lhs_mant};
    assign dbg_state     = state;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = bus.req_bypass ? DONE : ITER;
            ITER: if (last_step) state_next = DONE;
            DONE: if (bus.resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

`ifdef FP_DIV_SQRT_RADIX4_EN
    dp_t dp_mid;
    always_comb begin
        dp_mid  = recur_step(dp, is_div, divisor, 1'b0);
        dp_next = recur_step(dp_mid, is_div, divisor, last_step);
    end
`else
    always_comb begin
        dp_next = recur_step(dp, is_div, divisor, last_step);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp      <= '0;
            counter <= '0;
            divisor <= '0;
            is_div  <= 1'b0;
            tag_q   <= '0;
        end else if (accept) begin
            counter <= CNT_W'(ITERS - 1);
            divisor <= bus.req_rhs_mant;
            is_div  <= bus.req_is_divide;
            tag_q   <= bus.req_tag;
            dp      <= '0;
            if (!bus.req_bypass) begin
                if (bus.req_is_divide) dp.rem <= {4'b0, bus.req_lhs_mant};
                else                   dp.rad <= {sqrt_r, 27'b0};
            end
        end else if (state == ITER) begin
            dp <= dp_next;
            if (!last_step) counter <= counter - 1'b1;
        end
    end

    assign bus.resp_valid  = (state == DONE);
    assign bus.resp_quo    = dp.quo;
    assign bus.resp_rem    = dp.rem;
    assign bus.resp_sticky = |dp.rem;
    assign bus.resp_tag    = tag_q;

endmodule

// File: tb/tb_fp_div_sqrt_iter.sv
// Bench for fp_div_sqrt_iter: directed vectors, randomized ops against an arithmetic model,
// backpressure, flush and reset-in-flight scenarios.
module tb_fp_div_sqrt_iter;

`ifdef FP_DIV_SQRT_RADIX4_EN
    localparam int ITERS = 13;
`else
    localparam int ITERS = 26;
`endif
    localparam int W = 63;
    localparam int TIMEOUT = 100;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [1:0] dbg_state;
    int         cmp_cnt;
    int         err_cnt;
    logic [W-1:0] exp_q[$];

    fp_div_sqrt_iter_if #(.TAG_WIDTH(8)) bus ();

    fp_div_sqrt_iter #(.TAG_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic longint unsigned isqrt(input longint unsigned n);
        longint unsigned lo, hi, mid;
        lo = 0;
        hi = 64'd1 << 26;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= n) lo = mid;
            else hi = mid;
        end
        return lo;
    endfunction

    // {quo, rem, sticky, tag}: quotient = floor(lhs*2^25/rhs), root = floor(sqrt(R*2^27))
    function automatic logic [W-1:0] ref_model(input logic div, input logic byp, input logic odd,
                                               input logic [23:0] lhs, input logic [23:0] rhs,
                                               input logic [7:0] tag);
        longint unsigned n, q, r;
        if (byp) return {26'd0, 28'd0, 1'b0, tag};
        if (div) begin
            n = longint'(lhs) << 25;
            q = n / longint'(rhs);
            r = n - q * longint'(rhs);
        end else begin
            n = (odd ? longint'(lhs) * 2 : longint'(lhs)) << 27;
            q = isqrt(n);
            r = n - q * q;
        end
        return {q[25:0], r[27:0], (r != 0), tag};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic start_op(input logic div, input logic byp, input logic odd,
                            input logic [23:0] lhs, input logic [23:0] rhs, input logic [7:0] tag);
        bus.req_is_divide = div;
        bus.req_bypass    = byp;
        bus.req_expo_odd  = odd;
        bus.req_lhs_mant  = lhs;
        bus.req_rhs_mant  = rhs;
        bus.req_tag       = tag;
        bus.req_valid     = 1'b1;
        tick();
        bus.req_valid     = 1'b0;
    endtask

    // edges after the accept edge until resp_valid is seen (bypass responds straight after it)
    task automatic wait_resp(output int lat);
        lat = 0;
        while (!bus.resp_valid && lat < TIMEOUT) begin
            tick();
            lat++;
        end
    endtask

    task automatic finish_resp(output logic [W-1:0] got);
        got = {bus.resp_quo, bus.resp_rem, bus.resp_sticky, bus.resp_tag};
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
    endtask

    function automatic logic [23:0] rand_mant();
        return {1'b1, 23'($urandom_range(0, 32'h7FFFFF))};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        cmp_cnt++;
        if (bus.resp_valid !== 1'b0 || bus.resp_quo !== 26'd0 || bus.resp_rem !== 28'd0 ||
            bus.resp_sticky !== 1'b0 || bus.resp_tag !== 8'd0 || dbg_state !== 2'd0) begin
            err_cnt++;
            $display("FAIL reset_outputs: valid=%b quo=%h rem=%h sticky=%b tag=%h state=%0d expected all zero",
                     bus.resp_valid, bus.resp_quo, bus.resp_rem, bus.resp_sticky, bus.resp_tag, dbg_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        cmp_cnt++;
        if (bus.req_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_ready: req_ready=%b expected 1", bus.req_ready);
        end
    endtask

    task automatic test_directed();
        logic [23:0] lhs_v[4];
        logic [23:0] rhs_v[4];
        logic        div_v[4];
        logic        odd_v[4];
        logic [25:0] quo_v[4];
        logic        stk_v[4];
        logic [W-1:0] got, exp;
        logic [7:0]  tag;
        int          lat;
        lhs_v = '{24'h800000, 24'h800000, 24'h800000, 24'h800000};
        rhs_v = '{24'h800000, 24'hC00000, 24'h800000, 24'h800000};
        div_v = '{1'b1, 1'b1, 1'b0, 1'b0};
        odd_v = '{1'b0, 1'b0, 1'b0, 1'b1};
        quo_v = '{26'h2000000, 26'h1555555, 26'h2000000, 26'h2D413CC};
        stk_v = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            tag = 8'($urandom_range(0, 255));
            exp = ref_model(div_v[i], 1'b0, odd_v[i], lhs_v[i], rhs_v[i], tag);
            start_op(div_v[i], 1'b0, odd_v[i], lhs_v[i], rhs_v[i], tag);
            wait_resp(lat);
            finish_resp(got);
            cmp_cnt++;
            if (lat !== ITERS) begin
                err_cnt++;
                $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, ITERS);
            end
            cmp_cnt++;
            if (got[62:37] !== quo_v[i] || got[8] !== stk_v[i] || got[7:0] !== tag) begin
                err_cnt++;
                $display("FAIL directed_value[%0d]: quo=%h sticky=%b tag=%h expected quo=%h sticky=%b tag=%h",
                         i, got[62:37], got[8], got[7:0], quo_v[i], stk_v[i], tag);
            end
            cmp_cnt++;
            if (got !== exp) begin
                err_cnt++;
                $display("FAIL directed_model[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_bypass();
        logic [W-1:0] got;
        int lat;
        start_op(1'b1, 1'b1, 1'b0, 24'h912345, 24'hABCDEF, 8'hA5);
        wait_resp(lat);
        finish_resp(got);
        cmp_cnt++;
        if (lat !== 0 || got !== {26'd0, 28'd0, 1'b0, 8'hA5}) begin
            err_cnt++;
            $display("FAIL bypass: lat=%0d got %h expected lat=0 got %h", lat, got, {26'd0, 28'd0, 1'b0, 8'hA5});
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] snap, now, exp;
        int lat;
        exp = ref_model(1'b1, 1'b0, 1'b0, 24'hF00000, 24'h9AB000, 8'h3C);
        start_op(1'b1, 1'b0, 1'b0, 24'hF00000, 24'h9AB000, 8'h3C);
        wait_resp(lat);
        snap = {bus.resp_quo, bus.resp_rem, bus.resp_sticky, bus.resp_tag};
        for (int c = 0; c < 5; c++) begin
            tick();
            now = {bus.resp_quo, bus.resp_rem, bus.resp_sticky, bus.resp_tag};
            cmp_cnt++;
            if (now !== exp || bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0) begin
                err_cnt++;
                $display("FAIL hold[%0d]: out=%h valid=%b ready=%b expected out=%h valid=1 ready=0 (first %h)",
                         c, now, bus.resp_valid, bus.req_ready, exp, snap);
            end
        end
        finish_resp(now);
        cmp_cnt++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL hold_release: req_ready=%b resp_valid=%b expected 1/0", bus.req_ready, bus.resp_valid);
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] got, exp;
        int lat;
        bit seen;
        start_op(1'b1, 1'b0, 1'b0, 24'hC00000, 24'h800001, 8'h11);
        repeat (9) tick();
        flush = 1'b1;
        bus.req_is_divide = 1'b0;
        bus.req_lhs_mant  = 24'h900000;
        bus.req_valid     = 1'b1;
        #1;
        cmp_cnt++;
        if (bus.req_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL flush_ready: req_ready=%b expected 0", bus.req_ready);
        end
        tick();
        flush = 1'b0;
        bus.req_valid = 1'b0;
        cmp_cnt++;
        if (dbg_state !== 2'd0 || bus.resp_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL flush_kill: state=%0d resp_valid=%b expected 0/0", dbg_state, bus.resp_valid);
        end
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bus.resp_valid) seen = 1;
        end
        cmp_cnt++;
        if (seen !== 1'b0) begin
            err_cnt++;
            $display("FAIL flush_no_resp: resp_valid seen=%b expected 0", seen);
        end
        exp = ref_model(1'b1, 1'b0, 1'b0, 24'hD55555, 24'hB33333, 8'h77);
        start_op(1'b1, 1'b0, 1'b0, 24'hD55555, 24'hB33333, 8'h77);
        wait_resp(lat);
        finish_resp(got);
        cmp_cnt++;
        if (lat !== ITERS || got !== exp) begin
            err_cnt++;
            $display("FAIL flush_next_op: lat=%0d got %h expected lat=%0d got %h", lat, got, ITERS, exp);
        end
    endtask

    task automatic test_reset_mid();
        start_op(1'b0, 1'b0, 1'b1, 24'hABCDEF, 24'h800000, 8'h5A);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        cmp_cnt++;
        if (dbg_state !== 2'd0 || bus.resp_valid !== 1'b0 || bus.resp_quo !== 26'd0 ||
            bus.resp_rem !== 28'd0 || bus.resp_tag !== 8'd0) begin
            err_cnt++;
            $display("FAIL reset_mid: state=%0d valid=%b quo=%h rem=%h tag=%h expected all zero",
                     dbg_state, bus.resp_valid, bus.resp_quo, bus.resp_rem, bus.resp_tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [W-1:0] got, exp;
        logic div, byp, odd;
        logic [23:0] lhs, rhs;
        logic [7:0] tag;
        int lat;
        for (int i = 0; i < 60; i++) begin
            div = 1'($urandom_range(0, 1));
            byp = ($urandom_range(0, 7) == 0);
            odd = 1'($urandom_range(0, 1));
            lhs = rand_mant();
            rhs = rand_mant();
            tag = 8'($urandom_range(0, 255));
            exp_q.push_back(ref_model(div, byp, odd, lhs, rhs, tag));
            start_op(div, byp, odd, lhs, rhs, tag);
            wait_resp(lat);
            repeat ($urandom_range(0, 2)) tick();
            finish_resp(got);
            exp = exp_q.pop_front();
            cmp_cnt++;
            if (lat !== (byp ? 0 : ITERS) || got !== exp) begin
                err_cnt++;
                $display("FAIL random[%0d] div=%b byp=%b odd=%b lhs=%h rhs=%h: lat=%0d got %h expected lat=%0d got %h",
                         i, div, byp, odd, lhs, rhs, lat, got, (byp ? 0 : ITERS), exp);
            end
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        cmp_cnt = 0;
        err_cnt = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_is_divide = 1'b0;
        bus.req_bypass = 1'b0;
        bus.req_expo_odd = 1'b0;
        bus.req_lhs_mant = 24'h800000;
        bus.req_rhs_mant = 24'h800000;
        bus.req_tag = 8'd0;
        bus.resp_ready = 1'b0;
        test_reset();
        test_directed();
        test_bypass();
        test_hold();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
